dm_unit: RTL and testbench

//  - M-stage data memory for the 5-stage MIPS pipeline: word-addressed RAM with byte-lane stores (sw/sh/sb).
//  - Load path returns an extended result (lw/lh/lhu/lb/lbu). That result is registered into the M/W pipeline register as RD.
//  - Address comes from the E-stage ALU result (C); store data is the forwarded rt value.
//  - Flags misaligned accesses and suppresses their side effects.

---
 rtl/dm_unit_if.sv | 21 ++
 rtl/dm_unit.sv | 111 +++++++++++
 tb/tb_dm_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/dm_unit_if.sv
// Bus between the M-stage pipeline and the data memory: access request plus
// the combinational load result and misalignment flag.
interface dm_unit_if;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  mem_op;
    logic        mem_wr;
    logic [31:0] rdata;
    logic        align_err;

    modport master (
        output pc, addr, wdata, mem_op, mem_wr,
        input  rdata, align_err
    );

    modport slave (
        input  pc, addr, wdata, mem_op, mem_wr,
        output rdata, align_err
    );
endinterface

// File: rtl/dm_unit.sv
// M-stage data memory: word RAM with byte-lane stores and extended loads.
// Optional store trace enabled by defining DM_TRACE_EN.
module dm_unit #(
    parameter int unsigned ADDR_W = 10
) (
    input logic      clk,
    input logic      reset,
    dm_unit_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        OP_W  = 3'b000,
        OP_H  = 3'b001,
        OP_HU = 3'b010,
        OP_B  = 3'b011,
        OP_BU = 3'b100
    } mem_op_e;

    logic [31:0]       r_mem [0:DEPTH-1];
    mem_op_e           w_op;
    logic [ADDR_W-1:0] w_idx;
    logic [31:0]       w_word;
    logic [15:0]       w_half;
    logic [7:0]        w_byte;
    logic              w_mis;
    logic [31:0]       w_rdata;
    logic [31:0]       w_new_word;
    logic              w_unused;

    assign w_op   = mem_op_e'(bus.mem_op);
    assign w_idx  = bus.addr[ADDR_W+1:2];
    assign w_word = r_mem[w_idx];
    assign w_half = bus.addr[1] ? w_word[31:16] : w_word[15:0];

    // pc only feeds the optional trace; upper address bits wrap away
    assign w_unused = &{1'b0, bus.pc, bus.addr[31:ADDR_W+2]};

    always_comb begin
        w_byte = w_word[7:0];
        case (bus.addr[1:0])
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            2'd3:    w_byte = w_word[31:24];
            default: w_byte = w_word[7:0];
        endcase
    end

    always_comb begin
        w_mis = 1'b0;
        case (w_op)
            OP_H, OP_HU: w_mis = bus.addr[0];
            OP_B, OP_BU: w_mis = 1'b0;
            default:     w_mis = (bus.addr[1:0] != 2'b00);
        endcase
    end

    always_comb begin
        w_rdata = '0;
        if (!w_mis) begin
            case (w_op)
                OP_H:    w_rdata = {{16{w_half[15]}}, w_half};
                OP_HU:   w_rdata = {16'h0000, w_half};
                OP_B:    w_rdata = {{24{w_byte[7]}}, w_byte};
                OP_BU:   w_rdata = {24'h000000, w_byte};
                default: w_rdata = w_word;
            endcase
        end
    end

    // Full merged word is built here so the write and the trace agree.
    always_comb begin
        w_new_word = w_word;
        case (w_op)
            OP_H, OP_HU: begin
                if (bus.addr[1]) w_new_word[31:16] = bus.wdata[15:0];
                else             w_new_word[15:0]  = bus.wdata[15:0];
            end
            OP_B, OP_BU: begin
                case (bus.addr[1:0])
                    2'd1:    w_new_word[15:8]  = bus.wdata[7:0];
                    2'd2:    w_new_word[23:16] = bus.wdata[7:0];
                    2'd3:    w_new_word[31:24] = bus.wdata[7:0];
                    default: w_new_word[7:0]   = bus.wdata[7:0];
                endcase
            end
            default: w_new_word = bus.wdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (bus.mem_wr && !w_mis) begin
            r_mem[w_idx] <= w_new_word;
        end
    end

`ifdef DM_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && bus.mem_wr && !w_mis) begin
            $display("%d@%h: *%h <= %h", $time, bus.pc, {bus.addr[31:2], 2'b00}, w_new_word);
        end
    end
`endif

    assign bus.rdata     = w_rdata;
    assign bus.align_err = w_mis;
endmodule

// File: tb/tb_dm_unit.sv
// Scoreboard bench for dm_unit: byte-addressed reference model, directed
// cases followed by randomized accesses.
module tb_dm_unit;
    logic clk;
    logic reset;
    dm_unit_if bus ();

    dm_unit #(.ADDR_W(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  tb_mem [0:4095];
    logic [32:0] exp_q [$];
    logic [31:0] addr_q [$];
    logic [2:0]  op_q [$];
    bit          chk = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;

    function automatic int unsigned op_size(input logic [2:0] op);
        if (op == 3'd1 || op == 3'd2) return 2;
        if (op == 3'd3 || op == 3'd4) return 1;
        return 4;
    endfunction

    function automatic bit m_mis(input logic [31:0] a, input logic [2:0] op);
        return (a % op_size(op)) != 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] op);
        int unsigned sz = op_size(op);
        int unsigned b  = a % 4096;
        logic [31:0] v  = 32'h0;
        if (m_mis(a, op)) return 32'h0;
        for (int i = 0; i < int'(sz); i++) v[8*i +: 8] = tb_mem[b + i];
        if ((op == 3'd1 || op == 3'd3) && v[8*sz-1])
            for (int i = 8*int'(sz); i < 32; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 4096; i++) tb_mem[i] = 8'h00;
    endtask

    task automatic access(input bit rst, input bit wr, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] wd);
        int unsigned sz = op_size(op);
        int unsigned b  = a % 4096;
        @(posedge clk);
        #1;
        reset      = rst;
        bus.mem_wr = wr;
        bus.mem_op = op;
        bus.addr   = a;
        bus.wdata  = wd;
        bus.pc     = $urandom;
        exp_q.push_back({m_load(a, op), m_mis(a, op)});
        addr_q.push_back(a);
        op_q.push_back(op);
        chk = 1'b1;
        if (rst) m_clear();
        else if (wr && !m_mis(a, op))
            for (int i = 0; i < int'(sz); i++) tb_mem[b + i] = wd[8*i +: 8];
    endtask

    always @(negedge clk) begin
        if (chk) begin
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_underflow: no expected entry for DUT output");
            end else begin
                logic [32:0] e;
                logic [31:0] a;
                logic [2:0]  op;
                e  = exp_q.pop_front();
                a  = addr_q.pop_front();
                op = op_q.pop_front();
                vectors++;
                if (bus.rdata !== e[32:1] || bus.align_err !== e[0]) begin
                    miscompares++;
                    $display("FAIL load addr=%h op=%0d: got rdata=%h align_err=%b, expected rdata=%h align_err=%b",
                             a, op, bus.rdata, bus.align_err, e[32:1], e[0]);
                end
            end
        end
    end

    initial begin
        reset      = 1'b1;
        bus.mem_wr = 1'b0;
        bus.mem_op = 3'd0;
        bus.addr   = '0;
        bus.wdata  = '0;
        bus.pc     = '0;
        m_clear();
        @(posedge clk);
        @(posedge clk);

        // reset state
        access(0, 0, 3'd0, 32'h0,   32'h0);
        access(0, 0, 3'd0, 32'hFFC, 32'h0);
        // word store and extended loads
        access(0, 1, 3'd0, 32'h10, 32'h87654321);
        access(0, 0, 3'd0, 32'h10, 32'h0);
        access(0, 0, 3'd1, 32'h12, 32'h0);
        access(0, 0, 3'd2, 32'h12, 32'h0);
        access(0, 0, 3'd3, 32'h10, 32'h0);
        access(0, 0, 3'd3, 32'h13, 32'h0);
        access(0, 0, 3'd4, 32'h13, 32'h0);
        // partial stores
        access(0, 1, 3'd3, 32'h11, 32'hFFFFFFAB);
        access(0, 1, 3'd1, 32'h12, 32'h00001234);
        access(0, 0, 3'd0, 32'h10, 32'h0);
        // misalignment
        access(0, 1, 3'd1, 32'h13, 32'h0000FFFF);
        access(0, 0, 3'd0, 32'h10, 32'h0);
        access(0, 0, 3'd0, 32'h6,  32'h0);
        access(0, 1, 3'd0, 32'h2,  32'hCAFEF00D);
        access(0, 0, 3'd0, 32'h0,  32'h0);
        // address wrap
        access(0, 1, 3'd0, 32'h1000, 32'h1);
        access(0, 0, 3'd0, 32'h0,    32'h0);
        // reset priority and same-cycle read of a store target
        access(1, 1, 3'd0, 32'h20, 32'hDEADBEEF);
        access(0, 0, 3'd0, 32'h20, 32'h0);
        access(0, 0, 3'd0, 32'h10, 32'h0);
        access(0, 1, 3'd0, 32'h20, 32'h5);
        access(0, 0, 3'd0, 32'h20, 32'h0);
        // unused op codes behave as word
        access(0, 1, 3'd6, 32'h24, 32'hA5A5_0F0F);
        access(0, 0, 3'd7, 32'h24, 32'h0);
        access(0, 0, 3'd5, 32'h26, 32'h0);

        for (int n = 0; n < 500; n++) begin
            logic [31:0] a;
            a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            access(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
                   3'($urandom_range(0, 7)), a, $urandom);
        end

        @(posedge clk);
        #1;
        chk        = 1'b0;
        bus.mem_wr = 1'b0;
        @(posedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
